// File: rtl/cd_pkg.sv
// Shared definitions for the cd receive/transmit datapath blocks.
// Holds the statistics counter width and its saturating increment helper.
package cd_pkg;

   localparam int CD_CNT_W = 8;

   // Statistics counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [CD_CNT_W-1:0] cd_sat_inc(input logic [CD_CNT_W-1:0] v);
      return (v == '1) ? v : v + CD_CNT_W'(1);
   endfunction

endpackage

// File: rtl/cd_rx_page_ctrl.sv
// Receive page manager: a ring of rx RAM pages shared by the byte assembler (writer)
// and the host (reader), plus lost-frame and error statistics.
module cd_rx_page_ctrl
   import cd_pkg::*;
#(
   parameter int N_PAGES = 4,
   localparam int PTR_W  = $clog2(N_PAGES)
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_rx_en,
   input  logic                i_rx_switch,
   input  logic                i_rx_error,
   output logic [PTR_W-1:0]    o_wr_page,
   output logic [PTR_W-1:0]    o_rd_page,
   output logic                o_rd_valid,
   input  logic                i_rd_release,
   input  logic                i_rx_clear,
   output logic [PTR_W:0]      o_pend_cnt,
   output logic                o_lost_flag,
   output logic [CD_CNT_W-1:0] o_lost_cnt,
   output logic [CD_CNT_W-1:0] o_err_cnt,
   input  logic                i_cnt_clr
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(N_PAGES - 1);

   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [PTR_W:0]      r_pend_cnt;
   logic                r_rd_valid;
   logic                r_lost_flag;
   logic [CD_CNT_W-1:0] r_lost_cnt;
   logic [CD_CNT_W-1:0] r_err_cnt;

   logic                w_commit;
   logic                w_lost;
   logic [PTR_W-1:0]    w_wr_nxt;
   logic [PTR_W-1:0]    w_rd_nxt;
   logic [PTR_W:0]      w_pend_nxt;

   assign w_commit = i_rx_en & i_rx_switch;

   // Clear, then release, then commit; the commit sees the queue left by the first two,
   // so a release or clear in the same cycle frees room for an otherwise-lost frame.
   always_comb begin
      w_wr_nxt   = r_wr_ptr;
      w_rd_nxt   = r_rd_ptr;
      w_pend_nxt = r_pend_cnt;
      w_lost     = 1'b0;
      if (i_rx_clear) begin
         w_rd_nxt   = r_wr_ptr;
         w_pend_nxt = '0;
      end else if (i_rd_release && (r_pend_cnt != '0)) begin
         w_rd_nxt   = r_rd_ptr + PTR_W'(1);
         w_pend_nxt = r_pend_cnt - (PTR_W+1)'(1);
      end
      if (w_commit) begin
         if (w_pend_nxt == FULL_CNT) begin
            w_lost = 1'b1;
         end else begin
            w_wr_nxt   = r_wr_ptr + PTR_W'(1);
            w_pend_nxt = w_pend_nxt + (PTR_W+1)'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_pend_cnt <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_wr_ptr   <= w_wr_nxt;
         r_rd_ptr   <= w_rd_nxt;
         r_pend_cnt <= w_pend_nxt;
         r_rd_valid <= (w_pend_nxt != '0);
      end
   end

   // A counter clear wins over any increment arriving in the same cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_cnt_clr) begin
         r_lost_flag <= 1'b0;
         r_lost_cnt  <= '0;
         r_err_cnt   <= '0;
      end else begin
         if (w_lost) begin
            r_lost_flag <= 1'b1;
            r_lost_cnt  <= cd_sat_inc(r_lost_cnt);
         end
         if (i_rx_error) begin
            r_err_cnt <= cd_sat_inc(r_err_cnt);
         end
      end
   end

   assign o_wr_page   = r_wr_ptr;
   assign o_rd_page   = r_rd_ptr;
   assign o_rd_valid  = r_rd_valid;
   assign o_pend_cnt  = r_pend_cnt;
   assign o_lost_flag = r_lost_flag;
   assign o_lost_cnt  = r_lost_cnt;
   assign o_err_cnt   = r_err_cnt;

endmodule
